// File: rtl/rv32_decode_pkg.sv
// Shared constants and types for the RV32I decode stage.
//   - ALU operation codes and their width
//   - base opcode, funct3 and funct7 encodings
//   - decoded control bundle type and small decode helpers
// Optional M-extension ALU codes and the muldiv bundle flag exist only when
// RV32_MEXT_EN is defined.
package rv32_decode_pkg;

  localparam int ALU_OP_WIDTH = 5;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD  = 5'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB  = 5'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLL  = 5'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLT  = 5'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLTU = 5'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR  = 5'd5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRL  = 5'd6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRA  = 5'd7;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR   = 5'd8;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND  = 5'd9;
`ifdef RV32_MEXT_EN
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_MUL    = 5'd10;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_MULH   = 5'd11;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_MULHSU = 5'd12;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_MULHU  = 5'd13;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_DIV    = 5'd14;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_DIVU   = 5'd15;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_REM    = 5'd16;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_REMU   = 5'd17;
`endif

  localparam logic [6:0] RV32_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] RV32_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] RV32_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] RV32_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] RV32_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] RV32_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] RV32_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] RV32_OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] RV32_OPC_OP     = 7'b0110011;

  localparam logic [2:0] RV32_FUNCT3_ADD  = 3'b000;
  localparam logic [2:0] RV32_FUNCT3_SLL  = 3'b001;
  localparam logic [2:0] RV32_FUNCT3_SLT  = 3'b010;
  localparam logic [2:0] RV32_FUNCT3_SLTU = 3'b011;
  localparam logic [2:0] RV32_FUNCT3_XOR  = 3'b100;
  localparam logic [2:0] RV32_FUNCT3_SRL  = 3'b101;
  localparam logic [2:0] RV32_FUNCT3_OR   = 3'b110;
  localparam logic [2:0] RV32_FUNCT3_AND  = 3'b111;

  localparam logic [2:0] RV32_FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] RV32_FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] RV32_FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] RV32_FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] RV32_FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] RV32_FUNCT3_BGEU = 3'b111;

  localparam logic [2:0] RV32_FUNCT3_LB  = 3'b000;
  localparam logic [2:0] RV32_FUNCT3_LH  = 3'b001;
  localparam logic [2:0] RV32_FUNCT3_LW  = 3'b010;
  localparam logic [2:0] RV32_FUNCT3_LBU = 3'b100;
  localparam logic [2:0] RV32_FUNCT3_LHU = 3'b101;
  localparam logic [2:0] RV32_FUNCT3_SB  = 3'b000;
  localparam logic [2:0] RV32_FUNCT3_SH  = 3'b001;
  localparam logic [2:0] RV32_FUNCT3_SW  = 3'b010;

  localparam logic [6:0] RV32_FUNCT7_ZERO   = 7'b0000000;
  localparam logic [6:0] RV32_FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] RV32_FUNCT7_MULDIV = 7'b0000001;

  // Decoded control bundle; PC and immediate are carried separately because
  // their width follows the XLEN parameter of the stage.
  typedef struct packed {
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic [4:0]              rs1;
    logic [4:0]              rs2;
    logic [4:0]              rd;
    logic                    use_imm;
    logic                    rd_we;
    logic                    mem_rd;
    logic                    mem_wr;
    logic                    branch;
    logic                    jump;
`ifdef RV32_MEXT_EN
    logic                    muldiv;
`endif
    logic                    illegal;
  } ctl_t;

  // funct3 -> ALU op for the plain (funct7 = 0) register/immediate forms.
  function automatic logic [ALU_OP_WIDTH-1:0] alu_base_op(input logic [2:0] f3);
    case (f3)
      RV32_FUNCT3_ADD:  alu_base_op = ALU_OP_ADD;
      RV32_FUNCT3_SLL:  alu_base_op = ALU_OP_SLL;
      RV32_FUNCT3_SLT:  alu_base_op = ALU_OP_SLT;
      RV32_FUNCT3_SLTU: alu_base_op = ALU_OP_SLTU;
      RV32_FUNCT3_XOR:  alu_base_op = ALU_OP_XOR;
      RV32_FUNCT3_SRL:  alu_base_op = ALU_OP_SRL;
      RV32_FUNCT3_OR:   alu_base_op = ALU_OP_OR;
      default:          alu_base_op = ALU_OP_AND;
    endcase
  endfunction

`ifdef RV32_MEXT_EN
  function automatic logic [ALU_OP_WIDTH-1:0] alu_muldiv_op(input logic [2:0] f3);
    case (f3)
      3'b000:  alu_muldiv_op = ALU_OP_MUL;
      3'b001:  alu_muldiv_op = ALU_OP_MULH;
      3'b010:  alu_muldiv_op = ALU_OP_MULHSU;
      3'b011:  alu_muldiv_op = ALU_OP_MULHU;
      3'b100:  alu_muldiv_op = ALU_OP_DIV;
      3'b101:  alu_muldiv_op = ALU_OP_DIVU;
      3'b110:  alu_muldiv_op = ALU_OP_REM;
      default: alu_muldiv_op = ALU_OP_REMU;
    endcase
  endfunction
`endif

endpackage

// File: rtl/rv32_imm_gen.sv
// Immediate generator: picks the I/S/B/U/J immediate format from the opcode
// and sign-extends it to XLEN. R-type and unknown opcodes give 0.
// Ports:
//   instr  in  32    raw instruction
//   opcode in  7     instruction opcode (instr[6:0])
//   imm    out XLEN  sign-extended immediate
module rv32_imm_gen
  import rv32_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [6:0]      opcode,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;
  logic        unused_low_bits;

  // Opcode is supplied separately, so the low instruction bits are not needed here.
  assign unused_low_bits = ^instr[6:0];

  always_comb begin
    imm32 = '0;
    case (opcode)
      RV32_OPC_OP_IMM, RV32_OPC_LOAD, RV32_OPC_JALR:
        imm32 = {{20{instr[31]}}, instr[31:20]};
      RV32_OPC_STORE:
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      RV32_OPC_BRANCH:
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      RV32_OPC_LUI, RV32_OPC_AUIPC:
        imm32 = {instr[31:12], 12'b0};
      RV32_OPC_JAL:
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm32 = '0;
    endcase
  end

  // Signed cast carries bit 31 into the upper half when XLEN is 64.
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/rv32_decode_stage.sv
// Registered RV32I decode stage with a 2-entry skid buffer.
// Optional M-extension decode is enabled by defining RV32_MEXT_EN.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   flush                  drop everything buffered in this stage
//   in_valid/in_ready      upstream handshake; in_instr, in_pc
//   out_valid/out_ready    downstream handshake
//   out_pc, out_alu_op, out_imm, out_rs1/rs2/rd, out_use_imm, out_rd_we,
//   out_mem_rd, out_mem_wr, out_branch, out_jump, out_muldiv, out_illegal
//                          registered decoded bundle
module rv32_decode_stage
  import rv32_decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = ALU_OP_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [XLEN-1:0]     in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [ALU_OP_W-1:0] out_alu_op,
  output logic [XLEN-1:0]     out_imm,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [4:0]          out_rd,
  output logic                out_use_imm,
  output logic                out_rd_we,
  output logic                out_mem_rd,
  output logic                out_mem_wr,
  output logic                out_branch,
  output logic                out_jump,
  output logic                out_muldiv,
  output logic                out_illegal
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] dec_imm;
  ctl_t            dec_ctl;
  logic            shift_hi_zero;
  logic            shift_hi_sra;

  ctl_t            main_ctl, skid_ctl;
  logic [XLEN-1:0] main_imm, skid_imm;
  logic [XLEN-1:0] main_pc, skid_pc;
  logic            main_valid, skid_valid;
  logic            in_fire;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  rv32_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr  (in_instr),
    .opcode (opcode),
    .imm    (dec_imm)
  );

  // Shift-immediate upper bits; on RV64 bit 25 belongs to shamt.
  assign shift_hi_zero = (XLEN == 64) ? (in_instr[31:26] == 6'b000000)
                                      : (in_instr[31:25] == 7'b0000000);
  assign shift_hi_sra  = (XLEN == 64) ? (in_instr[31:26] == 6'b010000)
                                      : (in_instr[31:25] == 7'b0100000);

  // Every valid opcode ends in 2'b11, so instr[1:0] != 11 lands in the
  // default (unknown opcode) branch.
  always_comb begin
    dec_ctl        = '0;
    dec_ctl.rs1    = in_instr[19:15];
    dec_ctl.rs2    = in_instr[24:20];
    dec_ctl.rd     = in_instr[11:7];
    dec_ctl.alu_op = ALU_OP_ADD;
    case (opcode)
      RV32_OPC_OP: begin
        dec_ctl.rd_we = 1'b1;
        if (funct7 == RV32_FUNCT7_ZERO) begin
          dec_ctl.alu_op = alu_base_op(funct3);
        end else if (funct7 == RV32_FUNCT7_ALT && funct3 == RV32_FUNCT3_ADD) begin
          dec_ctl.alu_op = ALU_OP_SUB;
        end else if (funct7 == RV32_FUNCT7_ALT && funct3 == RV32_FUNCT3_SRL) begin
          dec_ctl.alu_op = ALU_OP_SRA;
`ifdef RV32_MEXT_EN
        end else if (funct7 == RV32_FUNCT7_MULDIV) begin
          dec_ctl.alu_op = alu_muldiv_op(funct3);
          dec_ctl.muldiv = 1'b1;
`endif
        end else begin
          dec_ctl.illegal = 1'b1;
        end
      end
      RV32_OPC_OP_IMM: begin
        dec_ctl.rd_we   = 1'b1;
        dec_ctl.use_imm = 1'b1;
        dec_ctl.alu_op  = alu_base_op(funct3);
        if (funct3 == RV32_FUNCT3_SLL) begin
          dec_ctl.illegal = !shift_hi_zero;
        end else if (funct3 == RV32_FUNCT3_SRL) begin
          if (shift_hi_sra) dec_ctl.alu_op = ALU_OP_SRA;
          else if (!shift_hi_zero) dec_ctl.illegal = 1'b1;
        end
      end
      RV32_OPC_BRANCH: begin
        dec_ctl.branch = 1'b1;
        case (funct3)
          RV32_FUNCT3_BEQ, RV32_FUNCT3_BNE:   dec_ctl.alu_op = ALU_OP_SUB;
          RV32_FUNCT3_BLT, RV32_FUNCT3_BGE:   dec_ctl.alu_op = ALU_OP_SLT;
          RV32_FUNCT3_BLTU, RV32_FUNCT3_BGEU: dec_ctl.alu_op = ALU_OP_SLTU;
          default:                            dec_ctl.illegal = 1'b1;
        endcase
      end
      RV32_OPC_LOAD: begin
        dec_ctl.rd_we   = 1'b1;
        dec_ctl.use_imm = 1'b1;
        dec_ctl.mem_rd  = 1'b1;
        case (funct3)
          RV32_FUNCT3_LB, RV32_FUNCT3_LH, RV32_FUNCT3_LW,
          RV32_FUNCT3_LBU, RV32_FUNCT3_LHU: dec_ctl.illegal = 1'b0;
          default:                          dec_ctl.illegal = 1'b1;
        endcase
      end
      RV32_OPC_STORE: begin
        dec_ctl.use_imm = 1'b1;
        dec_ctl.mem_wr  = 1'b1;
        case (funct3)
          RV32_FUNCT3_SB, RV32_FUNCT3_SH, RV32_FUNCT3_SW: dec_ctl.illegal = 1'b0;
          default:                                        dec_ctl.illegal = 1'b1;
        endcase
      end
      RV32_OPC_LUI: begin
        dec_ctl.rd_we   = 1'b1;
        dec_ctl.use_imm = 1'b1;
        dec_ctl.rs1     = 5'd0;
      end
      RV32_OPC_AUIPC: begin
        dec_ctl.rd_we   = 1'b1;
        dec_ctl.use_imm = 1'b1;
      end
      RV32_OPC_JAL, RV32_OPC_JALR: begin
        dec_ctl.rd_we   = 1'b1;
        dec_ctl.use_imm = 1'b1;
        dec_ctl.jump    = 1'b1;
      end
      default: dec_ctl.illegal = 1'b1;
    endcase
    // Illegal instructions still flow but must not cause side effects.
    if (dec_ctl.illegal) begin
      dec_ctl.rd_we  = 1'b0;
      dec_ctl.mem_rd = 1'b0;
      dec_ctl.mem_wr = 1'b0;
      dec_ctl.branch = 1'b0;
      dec_ctl.jump   = 1'b0;
    end
    if (dec_ctl.rd == 5'd0) dec_ctl.rd_we = 1'b0;
  end

  // in_ready depends only on registered skid state, never on out_ready.
  assign in_ready = !skid_valid;
  assign in_fire  = in_valid && in_ready;

  // Main register refills from skid first (keeps order), else from the
  // decoder; a stalled main parks a new accept in skid.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_ctl   <= '0;
      main_imm   <= '0;
      main_pc    <= '0;
      skid_ctl   <= '0;
      skid_imm   <= '0;
      skid_pc    <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || out_ready) begin
      if (skid_valid) begin
        main_ctl   <= skid_ctl;
        main_imm   <= skid_imm;
        main_pc    <= skid_pc;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        main_ctl   <= dec_ctl;
        main_imm   <= dec_imm;
        main_pc    <= in_pc;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_fire) begin
      skid_ctl   <= dec_ctl;
      skid_imm   <= dec_imm;
      skid_pc    <= in_pc;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid   = main_valid;
  assign out_pc      = main_pc;
  assign out_alu_op  = ALU_OP_W'(main_ctl.alu_op);
  assign out_imm     = main_imm;
  assign out_rs1     = main_ctl.rs1;
  assign out_rs2     = main_ctl.rs2;
  assign out_rd      = main_ctl.rd;
  assign out_use_imm = main_ctl.use_imm;
  assign out_rd_we   = main_ctl.rd_we;
  assign out_mem_rd  = main_ctl.mem_rd;
  assign out_mem_wr  = main_ctl.mem_wr;
  assign out_branch  = main_ctl.branch;
  assign out_jump    = main_ctl.jump;
`ifdef RV32_MEXT_EN
  assign out_muldiv  = main_ctl.muldiv;
`else
  assign out_muldiv  = 1'b0;
`endif
  assign out_illegal = main_ctl.illegal;

endmodule

// File: doc/rv32_decode_stage.md
Name: rv32_decode_stage

Overview:
- Registered RV32I instruction-decode pipeline stage. Sits between fetch and register-read/execute.
- Takes a raw 32-bit instruction plus its PC under a valid/ready handshake.
- Produces the full decoded bundle: ALU op, immediate, register indices, control flags and an illegal-instruction flag.
- A 2-entry skid buffer gives full throughput under backpressure. Generalises the combinational funct3/funct7 ALU-op mapping to all base opcodes, plus optional M-extension.

Parameters:
XLEN, 32, datapath/PC/immediate width; supported values 32 and 64; immediates sign-extended to XLEN
ALU_OP_W, `ALU_OP_WIDTH, width of out_alu_op (shared-package constant)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
flush  in  1  discard all buffered instructions this cycle
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept an instruction
in_instr  in  32  raw instruction
in_pc  in  XLEN  instruction PC
out_valid  out  1  decoded bundle valid
out_ready  in  1  downstream accepts the bundle
out_pc  out  XLEN  PC passthrough
out_alu_op  out  ALU_OP_W  ALU operation
out_imm  out  XLEN  sign-extended immediate (I/S/B/U/J by opcode; 0 for R-type)
out_rs1, out_rs2, out_rd  out  5 each  register indices
out_use_imm  out  1  ALU operand B = imm
out_rd_we  out  1  rd write enable; forced 0 when rd==0
out_mem_rd, out_mem_wr  out  1 each  load / store
out_branch, out_jump  out  1 each  conditional branch / JAL or JALR
out_muldiv  out  1  M-extension op (0 when feature is off)
out_illegal  out  1  undecodable instruction

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset: out_valid=0, skid_valid=0, in_ready=1. All bundle outputs are 0.
- Handshake: transfer when valid&&ready on either side. out_valid must not drop and bundle fields must not change while out_valid&&!out_ready.
- Latency: 1 cycle from in accept to out_valid when the output register is empty or draining.
- Skid buffer: main output register plus one skid register. in_ready = !skid_valid (registered; no combinational path from out_ready).
- Input accepted while the output is stalled goes to skid. On the next out accept, skid moves to main.
- Simultaneous in accept and out accept with skid empty: the new bundle loads main directly.
- Flush: next cycle out_valid=0 and skid_valid=0. An in accept in the same cycle is dropped. Flush beats a simultaneous in accept. Reset beats flush.
- Decode is combinational on in_instr and the result is registered; the raw instruction is not stored.
- ALU op, OP (0110011): funct3 map ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND.
  - funct7=0100000 legal only for funct3 000 (SUB) and 101 (SRA).
  - Any other funct7 except 0000000 is illegal (0000001 is covered under the optional feature).
- ALU op, OP-IMM (0010011): same map, but funct3=000 is always ADD.
  - funct3 001 requires imm[11:5]=0000000.
  - funct3 101 requires imm[11:5] of 0000000 (SRL) or 0100000 (SRA).
  - For XLEN=64, bit 25 is part of shamt and is excluded from the check.
- ALU op, BRANCH: beq/bne use SUB; blt/bge use SLT; bltu/bgeu use SLTU. funct3 010/011 are illegal.
- ALU op, ADD: LOAD, STORE, AUIPC, JAL, JALR, LUI. For LUI, out_rs1 is forced to 0.
- Illegal: unknown opcode, or instr[1:0]!=11. Any illegal instruction forces rd_we, mem_rd, mem_wr, branch and jump to 0; out_illegal=1 and the bundle still flows.
- Load/store funct3 legality: loads 000/001/010/100/101; stores 000/001/010. Otherwise illegal.

Optional Feature:
- Macro: RV32_MEXT_EN.
- Defined: OP with funct7=0000001 decodes funct3 to MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU ALU ops, with out_muldiv=1.
- Undefined: that encoding is illegal, out_muldiv is tied 0, and the ALU ops are not required in the package.

Decomposition:
- Shared package: ALU_OP_* codes, ALU_OP_WIDTH, RV32_OPC_* opcodes, RV32_FUNCT3_*, RV32_FUNCT7_* constants.
- One sub-module, rv32_imm_gen: combinational, instr[31:0] plus opcode to XLEN immediate.

Test Plan:
- in_instr=0x40B50533 (sub a0,a0,a1), out_ready=1 → next cycle out_valid=1, alu_op=SUB, rs1=10, rs2=11, rd=10, rd_we=1, illegal=0.
- srai a0,a0,3 (0x40355513) → SRA, use_imm=1, imm=0x403 (raw field); 0x60355513 → illegal=1, rd_we=0.
- Back-to-back stream of 4 ADDI, out_ready held 0 for 3 cycles after the first accept → in_ready drops after the second accept, no loss or duplication, in-order drain.
- Skid full, flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1, the flushed instructions never appear.
- beq x1,x2,-8 (0xFE208CE3) → branch=1, alu_op=SUB, imm=0xFFFFFFF8, rd_we=0; jal x0,+16 → jump=1, rd_we=0.
- mul (0x02B50533) → with RV32_MEXT_EN: muldiv=1, alu_op=MUL; without: illegal=1.
